// File: rtl/mcu_pkg.sv
// Shared MCU definitions: decoder op encodings and default geometry of the PC/stack block.
package mcu_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam logic [11:0] IRQ_VEC_DEF = 12'hFF0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_JC   = 4'd2,
        OP_JZ   = 4'd3,
        OP_CALL = 4'd4,
        OP_RET  = 4'd5,
        OP_PUSH = 4'd6,
        OP_POP  = 4'd7,
        OP_RETI = 4'd8,
        OP_HALT = 4'd9
    } op_e;

endpackage

// File: rtl/lifo_mem.sv
// Stack storage: one synchronous write port, one combinational read port, no reset.
module lifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pc_stack_ctrl.sv
// Program counter sequencing with a hardware call/data stack and a single-level interrupt.
// One op per clock; stack faults freeze the block until reset.
module pc_stack_ctrl
    import mcu_pkg::*;
#(
    parameter int unsigned       ADDR_W  = ADDR_W_DEF,
    parameter int unsigned       DATA_W  = DATA_W_DEF,
    parameter int unsigned       DEPTH   = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(IRQ_VEC_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               op,
    input  logic [ADDR_W-1:0]        br_addr,
    input  logic                     c_in,
    input  logic                     z_in,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     irq,
    input  logic                     ie,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   sp,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     in_isr,
    output logic                     err_ovf,
    output logic                     err_udf,
    output logic                     halted
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned SP_W = AW + 1;

    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_tgt;
    logic [SP_W-1:0]   sp_nxt;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [DATA_W-1:0] pop_data_nxt;
    logic              pop_valid_nxt;
    logic              in_isr_nxt;
    logic              err_ovf_nxt;
    logic              err_udf_nxt;
    logic              halted_nxt;

    logic              take_irq;
    logic              push_req;
    logic              pop_req;
    logic              pop_to_pc;
    logic              clr_isr;
    logic [DATA_W-1:0] push_val;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign pc_inc   = pc + ADDR_W'(1);
    assign sp_inc   = sp + SP_W'(1);
    assign sp_dec   = sp - SP_W'(1);
    assign wr_addr  = sp[AW-1:0];
    assign rd_addr  = sp_dec[AW-1:0];
    assign take_irq = irq & ie & ~in_isr & ~full & ~halted;

    lifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_lifo_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Decode the op (or the interrupt that overrides it) into stack requests, then
    // resolve those against full/empty so faults leave pc and sp untouched.
    always_comb begin
        pc_nxt        = pc;
        sp_nxt        = sp;
        pop_data_nxt  = pop_data;
        pop_valid_nxt = 1'b0;
        in_isr_nxt    = in_isr;
        err_ovf_nxt   = err_ovf;
        err_udf_nxt   = err_udf;
        halted_nxt    = halted;
        push_req      = 1'b0;
        pop_req       = 1'b0;
        pop_to_pc     = 1'b0;
        clr_isr       = 1'b0;
        push_val      = '0;
        pc_tgt        = pc_inc;
        wr_en         = 1'b0;
        wr_data       = '0;

        if (!halted) begin
            if (take_irq) begin
                push_req   = 1'b1;
                push_val   = DATA_W'(pc);
                pc_tgt     = IRQ_VEC;
                in_isr_nxt = 1'b1;
            end else begin
                case (op)
                    OP_JMP:  pc_nxt = br_addr;
                    OP_JC:   pc_nxt = c_in ? br_addr : pc_inc;
                    OP_JZ:   pc_nxt = z_in ? br_addr : pc_inc;
                    OP_CALL: begin
                        push_req = 1'b1;
                        push_val = DATA_W'(pc_inc);
                        pc_tgt   = br_addr;
                    end
                    OP_RET: begin
                        pop_req   = 1'b1;
                        pop_to_pc = 1'b1;
                    end
                    OP_PUSH: begin
                        push_req = 1'b1;
                        push_val = push_data;
                    end
                    OP_POP:  pop_req = 1'b1;
                    OP_RETI: begin
                        pop_req   = 1'b1;
                        pop_to_pc = 1'b1;
                        clr_isr   = 1'b1;
                    end
                    OP_HALT: halted_nxt = 1'b1;
                    default: pc_nxt = pc_inc;
                endcase
            end

            if (push_req) begin
                if (full) begin
                    err_ovf_nxt = 1'b1;
                    halted_nxt  = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = push_val;
                    sp_nxt  = sp_inc;
                    pc_nxt  = pc_tgt;
                end
            end

            if (pop_req) begin
                if (empty) begin
                    err_udf_nxt = 1'b1;
                    halted_nxt  = 1'b1;
                end else begin
                    sp_nxt = sp_dec;
                    if (pop_to_pc) begin
                        pc_nxt = rd_data[ADDR_W-1:0];
                    end else begin
                        pop_data_nxt  = rd_data;
                        pop_valid_nxt = 1'b1;
                        pc_nxt        = pc_inc;
                    end
                    if (clr_isr) begin
                        in_isr_nxt = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            in_isr    <= 1'b0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            sp        <= sp_nxt;
            pop_data  <= pop_data_nxt;
            pop_valid <= pop_valid_nxt;
            in_isr    <= in_isr_nxt;
            err_ovf   <= err_ovf_nxt;
            err_udf   <= err_udf_nxt;
            halted    <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Scoreboard bench for pc_stack_ctrl: directed ops queue expected state and pops,
// a monitor compares one cycle later.
module tb_pc_stack_ctrl;
    import mcu_pkg::*;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_FULL  = 6'b100000;
    localparam logic [5:0] F_EMPTY = 6'b010000;
    localparam logic [5:0] F_ISR   = 6'b001000;
    localparam logic [5:0] F_OVF   = 6'b000100;
    localparam logic [5:0] F_UDF   = 6'b000010;
    localparam logic [5:0] F_HALT  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  op = 4'd0;
    logic [11:0] br_addr = '0;
    logic        c_in = 1'b0;
    logic        z_in = 1'b0;
    logic [15:0] push_data = '0;
    logic        irq = 1'b0;
    logic        ie = 1'b0;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        full, empty, in_isr, err_ovf, err_udf, halted;

    pc_stack_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .br_addr(br_addr), .c_in(c_in), .z_in(z_in),
        .push_data(push_data), .irq(irq), .ie(ie), .pc(pc), .sp(sp),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .in_isr(in_isr), .err_ovf(err_ovf), .err_udf(err_udf), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] pc;
        logic [4:0]  sp;
        logic [5:0]  flg;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } pop_t;

    exp_t expq[$];
    pop_t popq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] flags_now();
        return {full, empty, in_isr, err_ovf, err_udf, halted};
    endfunction

    // Monitor: compares queued state expectations and the pop_valid/pop_data stream.
    exp_t e;
    pop_t p;
    always @(posedge clk) begin
        #1;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            checks++; failures++;
            $display("FAIL state_missed cyc=%0d got none want pc=%h", e.cyc, e.pc);
        end
        while (popq.size() > 0 && popq[0].cyc < cyc) begin
            p = popq.pop_front();
            checks++; failures++;
            $display("FAIL pop_missed cyc=%0d got none want %h", p.cyc, p.data);
        end
        if (popq.size() > 0 && popq[0].cyc == cyc) begin
            p = popq.pop_front();
            checks++;
            if (pop_valid !== 1'b1 || pop_data !== p.data) begin
                failures++;
                $display("FAIL pop cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                         cyc, pop_valid, pop_data, p.data);
            end
        end else begin
            checks++;
            if (pop_valid !== 1'b0) begin
                failures++;
                $display("FAIL pop_valid_unexpected cyc=%0d got 1 data=%h want 0", cyc, pop_data);
            end
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            checks++;
            if (pc !== e.pc) begin
                failures++;
                $display("FAIL pc cyc=%0d got %h want %h", cyc, pc, e.pc);
            end
            checks++;
            if (sp !== e.sp) begin
                failures++;
                $display("FAIL sp cyc=%0d got %0d want %0d", cyc, sp, e.sp);
            end
            checks++;
            if (flags_now() !== e.flg) begin
                failures++;
                $display("FAIL flags cyc=%0d got %b want %b (full,empty,isr,ovf,udf,halt)",
                         cyc, flags_now(), e.flg);
            end
        end
    end

    // Entered and left at a negedge: drive one op and queue the post-edge state.
    task automatic step(input logic [3:0] o, input logic [11:0] a, input logic c, input logic z,
                        input logic i, input logic en, input logic [15:0] pd,
                        input logic [11:0] epc, input logic [4:0] esp, input logic [5:0] eflg);
        op = o; br_addr = a; c_in = c; z_in = z; irq = i; ie = en; push_data = pd;
        expq.push_back('{cyc + 1, epc, esp, eflg});
        @(negedge clk);
    endtask

    task automatic expect_pop(input logic [15:0] d);
        popq.push_back('{cyc + 1, d});
    endtask

    // Reset while op is presented; reset must take effect immediately and abort the op.
    task automatic do_reset(input logic [3:0] o);
        rst = 1'b1; op = o; irq = 1'b0; ie = 1'b0; push_data = 16'hFFFF;
        #1;
        checks++;
        if (pc !== 12'h000 || sp !== 5'd0 || pop_data !== 16'h0000 || pop_valid !== 1'b0 ||
            flags_now() !== F_EMPTY) begin
            failures++;
            $display("FAIL reset_async got pc=%h sp=%0d pd=%h pv=%b flg=%b want 000 0 0000 0 %b",
                     pc, sp, pop_data, pop_valid, flags_now(), F_EMPTY);
        end
        expq.push_back('{cyc + 1, 12'h000, 5'd0, F_EMPTY});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(OP_NOP);

        // Sequential NOPs, conditional branches, undefined codes
        for (int k = 1; k <= 5; k++)
            step(OP_NOP, 12'h0, 0, 0, 0, 0, 16'h0, 12'(k), 5'd0, F_EMPTY);
        step(OP_JC, 12'h040, 0, 0, 0, 0, 16'h0, 12'h006, 5'd0, F_EMPTY);
        step(OP_JC, 12'h040, 1, 0, 0, 0, 16'h0, 12'h040, 5'd0, F_EMPTY);
        step(OP_JZ, 12'h077, 1, 0, 0, 0, 16'h0, 12'h041, 5'd0, F_EMPTY);
        step(OP_JZ, 12'h050, 0, 1, 0, 0, 16'h0, 12'h050, 5'd0, F_EMPTY);
        step(4'hF,  12'h300, 1, 1, 0, 0, 16'h0, 12'h051, 5'd0, F_EMPTY);
        step(4'hA,  12'h300, 1, 1, 0, 0, 16'h0, 12'h052, 5'd0, F_EMPTY);

        // CALL/RET
        step(OP_JMP,  12'h010, 0, 0, 0, 0, 16'h0, 12'h010, 5'd0, F_EMPTY);
        step(OP_CALL, 12'h200, 0, 0, 0, 0, 16'h0, 12'h200, 5'd1, F_NONE);
        step(OP_RET,  12'h000, 0, 0, 0, 0, 16'h0, 12'h011, 5'd0, F_EMPTY);

        // PUSH/POP and LIFO order
        step(OP_PUSH, 12'h0, 0, 0, 0, 0, 16'hA5A5, 12'h012, 5'd1, F_NONE);
        expect_pop(16'hA5A5);
        step(OP_POP,  12'h0, 0, 0, 0, 0, 16'h0,    12'h013, 5'd0, F_EMPTY);
        step(OP_NOP,  12'h0, 0, 0, 0, 0, 16'h0,    12'h014, 5'd0, F_EMPTY);
        step(OP_PUSH, 12'h0, 0, 0, 0, 0, 16'h1111, 12'h015, 5'd1, F_NONE);
        step(OP_PUSH, 12'h0, 0, 0, 0, 0, 16'h2222, 12'h016, 5'd2, F_NONE);
        expect_pop(16'h2222);
        step(OP_POP,  12'h0, 0, 0, 0, 0, 16'h0,    12'h017, 5'd1, F_NONE);
        expect_pop(16'h1111);
        step(OP_POP,  12'h0, 0, 0, 0, 0, 16'h0,    12'h018, 5'd0, F_EMPTY);

        // pc wrap
        step(OP_JMP, 12'hFFF, 0, 0, 0, 0, 16'h0, 12'hFFF, 5'd0, F_EMPTY);
        step(OP_NOP, 12'h000, 0, 0, 0, 0, 16'h0, 12'h000, 5'd0, F_EMPTY);

        // Overflow: reset aborts a presented PUSH, then fill and overflow
        step(OP_JMP, 12'h0AB, 0, 0, 0, 0, 16'h0, 12'h0AB, 5'd0, F_EMPTY);
        do_reset(OP_PUSH);
        for (int k = 1; k <= 16; k++)
            step(OP_PUSH, 12'h0, 0, 0, 0, 0, 16'(16'h1000 + k), 12'(k), 5'(k),
                 (k == 16) ? F_FULL : F_NONE);
        step(OP_PUSH, 12'h0,   0, 0, 0, 0, 16'hDEAD, 12'h010, 5'd16, F_FULL | F_OVF | F_HALT);
        step(OP_JMP,  12'h123, 0, 0, 0, 0, 16'h0,    12'h010, 5'd16, F_FULL | F_OVF | F_HALT);
        step(OP_POP,  12'h0,   0, 0, 1, 1, 16'h0,    12'h010, 5'd16, F_FULL | F_OVF | F_HALT);

        // irq deferred while full, taken once space frees
        do_reset(OP_NOP);
        for (int k = 1; k <= 16; k++)
            step(OP_PUSH, 12'h0, 0, 0, 0, 0, 16'(16'h1000 + k), 12'(k), 5'(k),
                 (k == 16) ? F_FULL : F_NONE);
        step(OP_NOP, 12'h0, 0, 0, 1, 1, 16'h0, 12'h011, 5'd16, F_FULL);
        expect_pop(16'h1010);
        step(OP_POP, 12'h0, 0, 0, 1, 1, 16'h0, 12'h012, 5'd15, F_NONE);
        step(OP_NOP, 12'h0, 0, 0, 1, 1, 16'h0, 12'hFF0, 5'd16, F_FULL | F_ISR);
        expect_pop(16'h0012);
        step(OP_POP, 12'h0, 0, 0, 0, 0, 16'h0, 12'hFF1, 5'd15, F_ISR);

        // Underflow
        do_reset(OP_NOP);
        step(OP_POP, 12'h0,   0, 0, 0, 0, 16'h0, 12'h000, 5'd0, F_EMPTY | F_UDF | F_HALT);
        step(OP_JMP, 12'h055, 0, 0, 0, 0, 16'h0, 12'h000, 5'd0, F_EMPTY | F_UDF | F_HALT);

        // Interrupt entry, masking, RET vs RETI, re-execution of the overridden op
        do_reset(OP_NOP);
        step(OP_JMP,  12'h033, 0, 0, 0, 0, 16'h0,    12'h033, 5'd0, F_EMPTY);
        step(OP_JMP,  12'h100, 0, 0, 1, 1, 16'h0,    12'hFF0, 5'd1, F_ISR);
        step(OP_NOP,  12'h0,   0, 0, 1, 1, 16'h0,    12'hFF1, 5'd1, F_ISR);
        expect_pop(16'h0033);
        step(OP_POP,  12'h0,   0, 0, 1, 1, 16'h0,    12'hFF2, 5'd0, F_EMPTY | F_ISR);
        step(OP_PUSH, 12'h0,   0, 0, 1, 1, 16'h0033, 12'hFF3, 5'd1, F_ISR);
        step(OP_CALL, 12'h300, 0, 0, 1, 1, 16'h0,    12'h300, 5'd2, F_ISR);
        step(OP_RET,  12'h0,   0, 0, 1, 1, 16'h0,    12'hFF4, 5'd1, F_ISR);
        step(OP_RETI, 12'h0,   0, 0, 0, 1, 16'h0,    12'h033, 5'd0, F_EMPTY);
        step(OP_JMP,  12'h100, 0, 0, 1, 0, 16'h0,    12'h100, 5'd0, F_EMPTY);

        op = OP_NOP; irq = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0 || popq.size() != 0) begin
            failures++;
            $display("FAIL drain got exp=%0d pop=%0d want 0 0", expq.size(), popq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_stack_ctrl.md
PC_STACK_CTRL -- requirements
Module: pc_stack_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 12, program-counter width.
REQ-002 SHALL take parameter DATA_W, default 16, stack entry width; DATA_W >= ADDR_W.
REQ-003 SHALL take parameter DEPTH, default 16, stack entries; power of two, >= 2.
REQ-004 SHALL take parameter IRQ_VEC, default 12'hFF0, interrupt entry address.
REQ-005 SHALL have the following ports, clock and reset first:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- op, input, 4: operation code from the decoder; encodings in mcu_pkg.
- br_addr, input, ADDR_W: branch or call target.
- c_in, input, 1: carry flag.
- z_in, input, 1: zero flag.
- push_data, input, DATA_W: A-register value for PUSH.
- irq, input, 1: level interrupt request.
- ie, input, 1: interrupt enable.
- pc, output, ADDR_W: program counter, registered.
- sp, output, clog2(DEPTH)+1: occupancy, registered.
- pop_data, output, DATA_W: popped value, registered.
- pop_valid, output, 1: one-cycle pulse when pop_data is updated.
- full, output, 1: sp == DEPTH.
- empty, output, 1: sp == 0.
- in_isr, output, 1: an interrupt is being serviced.
- err_ovf, output, 1: sticky overflow.
- err_udf, output, 1: sticky underflow.
- halted, output, 1: sticky halt.

Function
REQ-006 SHALL execute one op per rising clk edge; all effects SHALL be visible the cycle after the edge.
REQ-007 SHALL implement the following ops:
- NOP: pc+1.
- JMP: pc=br_addr.
- JC: pc=br_addr if c_in, else pc+1.
- JZ: pc=br_addr if z_in, else pc+1.
- CALL: push zero-extended pc+1; pc=br_addr.
- RET: pop into pc, using the low ADDR_W bits.
- PUSH: push push_data; pc+1.
- POP: pop into pop_data; pulse pop_valid; pc+1.
- RETI: as RET, and clear in_isr.
- HALT: set halted; pc unchanged.
- Any undefined code: treated as NOP.
REQ-008 pc+1 SHALL wrap modulo 2^ADDR_W; 0xFFF+1 gives 0x000 at the default width.
REQ-009 A push SHALL write entry[sp] and set sp=sp+1. A pop SHALL read entry[sp-1] and set sp=sp-1 (LIFO).
REQ-010 A push with full=1 SHALL write nothing, leave sp and pc unchanged, and set err_ovf and halted.
REQ-011 A pop, RET or RETI with empty=1 SHALL leave sp and pc unchanged, set err_udf and halted, and not pulse pop_valid.
REQ-012 While halted=1, all ops and irq SHALL be ignored; pc, sp and the stack SHALL hold until rst.
REQ-013 Interrupt take condition: irq & ie & !in_isr & !full & !halted at the edge.
REQ-014 When taken, the interrupt SHALL override op: push the current pc (the address of the un-executed instruction), set pc=IRQ_VEC, and set in_isr.
- The overridden op SHALL re-execute after RETI.
REQ-015 An irq with full=1 SHALL be deferred, not dropped, and SHALL NOT raise err_ovf.
REQ-016 in_isr=1 SHALL mask irq. Nested interrupts are not supported.
REQ-017 RET inside the ISR SHALL NOT clear in_isr; only RETI clears it.
REQ-018 pop_data SHALL hold its last value when no POP executes.
REQ-019 full and empty SHALL be combinational decodes of the registered sp.

Reset
REQ-020 rst=1 SHALL immediately set pc=0, sp=0, pop_data=0, pop_valid=0, in_isr=0, err_ovf=0, err_udf=0 and halted=0.
REQ-021 Stack contents SHALL NOT be reset and are undefined after reset.
REQ-022 rst asserted mid-operation SHALL abort any push or pop. The first op after rst deasserts SHALL execute with pc=0.

Structure
REQ-023 Op encodings, ADDR_W/DATA_W/DEPTH defaults and IRQ_VEC SHALL reside in shared package mcu_pkg.
- Encodings: NOP=0, JMP=1, JC=2, JZ=3, CALL=4, RET=5, PUSH=6, POP=7, RETI=8, HALT=9.
REQ-024 Stack storage SHALL be sub-module lifo_mem (DEPTH x DATA_W, one write port and one combinational read port), instantiated once.
REQ-025 The sequencing/priority logic SHALL stay in pc_stack_ctrl.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset, then 5 NOPs -> pc 0,1,2,3,4,5; sp=0; empty=1.
- CALL 0x200 at pc=0x010, then RET -> pc=0x200 then 0x011; sp 1 then 0.
- PUSH 0xA5A5 then POP -> pop_data=0xA5A5 with pop_valid for exactly one cycle; sp back to 0.
- 16 PUSHes then a 17th -> full=1 after the 16th; the 17th sets err_ovf and halted, sp stays 16, pc frozen; a subsequent JMP is ignored.
- POP with empty=1 -> err_udf=1, halted=1, pop_valid=0.
- irq=1, ie=1 at pc=0x033 with op=JMP 0x100 -> pc=0xFF0, in_isr=1, stack top=0x033; a second irq is ignored; RETI -> pc=0x033; JMP re-executes giving pc=0x100.
